rt_gray_cnt_rx: RTL and testbench



---
 rtl/rt_gray_cnt_rx.sv | 153 +++++++++++++++
 tb/tb_rt_gray_cnt_rx.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rt_gray_cnt_rx.sv
// Gray-count receiver: synchronizes a remote Gray count, decodes it, tracks movement and flags multi-bit jumps.
// Optional: define RT_GRAY_RX_STAT_EN to add the saturating violation counter output rt_o_viol_cnt.
module rt_gray_cnt_rx #(
  parameter int PARAM_BIT_NUM  = 32,
  parameter int PARAM_SYNC_STG = 2,
  parameter int PARAM_ERR_MAX  = 3
) (
  input  logic                     rt_i_clk,
  input  logic                     rt_i_rst_n,
  input  logic                     rt_i_en,
  input  logic [PARAM_BIT_NUM-1:0] rt_i_gray,
  input  logic                     rt_i_clr_err,
  output logic [PARAM_BIT_NUM-1:0] rt_o_bin,
  output logic                     rt_o_vld,
  output logic [PARAM_BIT_NUM-1:0] rt_o_delta,
  output logic                     rt_o_chg,
  output logic                     rt_o_dir,
  output logic                     rt_o_err
`ifdef RT_GRAY_RX_STAT_EN
  ,
  output logic [15:0]              rt_o_viol_cnt
`endif
);

  localparam int CNT_W = $clog2(PARAM_ERR_MAX + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ACQ, ST_TRACK, ST_ERR} state_t;

  state_t                                      state_q, state_d;
  logic [PARAM_SYNC_STG-1:0][PARAM_BIT_NUM-1:0] sync_q;
  logic [PARAM_BIT_NUM-1:0]                    gray_s, bin_dec, delta_new;
  logic [PARAM_BIT_NUM-1:0]                    gray_prev_q, gray_prev_d;
  logic [PARAM_BIT_NUM-1:0]                    bin_q, bin_d, delta_q, delta_d;
  logic                                        chg_q, chg_d, dir_q, dir_d, err_q, err_d;
  logic [CNT_W-1:0]                            bad_cnt_q, bad_cnt_d;
  logic                                        viol;
  int                                          hd;

  // NOTE: the synchronizer flops are reset as well, so gray_s is a known 0 right after reset.
  always_ff @(posedge rt_i_clk or negedge rt_i_rst_n) begin
    if (!rt_i_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= rt_i_gray;
      for (int i = 1; i < PARAM_SYNC_STG; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign gray_s    = sync_q[PARAM_SYNC_STG-1];
  assign hd        = $countones(gray_s ^ gray_prev_q);
  assign delta_new = bin_dec - bin_q;

  // Each binary bit is the XOR of all Gray bits at or above its position.
  always_comb begin
    bin_dec = '0;
    for (int i = 0; i < PARAM_BIT_NUM; i++) bin_dec[i] = ^(gray_s >> i);
  end

  // NOTE: every signal gets its hold/default value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    gray_prev_d = gray_prev_q;
    bin_d       = bin_q;
    delta_d     = delta_q;
    chg_d       = 1'b0;
    dir_d       = dir_q;
    err_d       = err_q;
    bad_cnt_d   = bad_cnt_q;
    viol        = 1'b0;
    if (!rt_i_en) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_ACQ;
        ST_ACQ: begin
          gray_prev_d = gray_s;
          bin_d       = bin_dec;
          delta_d     = '0;
          bad_cnt_d   = '0;
          state_d     = ST_TRACK;
        end
        ST_TRACK: begin
          if (hd == 0) begin
            bad_cnt_d = '0;
          end else if (hd == 1) begin
            gray_prev_d = gray_s;
            bin_d       = bin_dec;
            delta_d     = delta_new;
            chg_d       = 1'b1;
            dir_d       = (delta_new == '1);
            bad_cnt_d   = '0;
          end else begin
            viol      = 1'b1;
            bad_cnt_d = bad_cnt_q + 1'b1;
            if (bad_cnt_q == CNT_W'(PARAM_ERR_MAX - 1)) begin
              state_d = ST_ERR;
              err_d   = 1'b1;
            end
          end
        end
        ST_ERR: if (rt_i_clr_err) state_d = ST_ACQ;
        default: state_d = ST_IDLE;
      endcase
    end
    if (rt_i_clr_err) err_d = 1'b0;
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge rt_i_clk or negedge rt_i_rst_n) begin
    if (!rt_i_rst_n) begin
      state_q     <= ST_IDLE;
      gray_prev_q <= '0;
      bin_q       <= '0;
      delta_q     <= '0;
      chg_q       <= 1'b0;
      dir_q       <= 1'b0;
      err_q       <= 1'b0;
      bad_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      gray_prev_q <= gray_prev_d;
      bin_q       <= bin_d;
      delta_q     <= delta_d;
      chg_q       <= chg_d;
      dir_q       <= dir_d;
      err_q       <= err_d;
      bad_cnt_q   <= bad_cnt_d;
    end
  end

  assign rt_o_bin   = bin_q;
  assign rt_o_vld   = (state_q == ST_TRACK);
  assign rt_o_delta = delta_q;
  assign rt_o_chg   = chg_q;
  assign rt_o_dir   = dir_q;
  assign rt_o_err   = err_q;

`ifdef RT_GRAY_RX_STAT_EN
  logic [15:0] viol_cnt_q;

  always_ff @(posedge rt_i_clk or negedge rt_i_rst_n) begin
    if (!rt_i_rst_n)                       viol_cnt_q <= '0;
    else if (rt_i_clr_err)                 viol_cnt_q <= '0;
    else if (viol && viol_cnt_q != 16'hFFFF) viol_cnt_q <= viol_cnt_q + 16'd1;
  end

  assign rt_o_viol_cnt = viol_cnt_q;
`else
  logic unused_viol;
  assign unused_viol = viol;
`endif

endmodule

// File: tb/tb_rt_gray_cnt_rx.sv
// Self-checking bench for rt_gray_cnt_rx: directed scenarios plus a randomized walk,
// compared every cycle against a cycle-level behavioural model of the receiver.
module tb_rt_gray_cnt_rx;
  localparam int N    = 32;
  localparam int STG  = 2;
  localparam int EMAX = 3;
  localparam int M_IDLE = 0, M_ACQ = 1, M_TRACK = 2, M_ERR = 3;

  logic         clk = 1'b0, rst_n = 1'b0, en = 1'b0, clr = 1'b0;
  logic [N-1:0] gray = '0;
  logic [N-1:0] bin, delta;
  logic         vld, chg, dir, err;
`ifdef RT_GRAY_RX_STAT_EN
  logic [15:0]  viol_cnt;
`endif

  rt_gray_cnt_rx #(.PARAM_BIT_NUM(N), .PARAM_SYNC_STG(STG), .PARAM_ERR_MAX(EMAX)) dut (
    .rt_i_clk     (clk),
    .rt_i_rst_n   (rst_n),
    .rt_i_en      (en),
    .rt_i_gray    (gray),
    .rt_i_clr_err (clr),
    .rt_o_bin     (bin),
    .rt_o_vld     (vld),
    .rt_o_delta   (delta),
    .rt_o_chg     (chg),
    .rt_o_dir     (dir),
    .rt_o_err     (err)
`ifdef RT_GRAY_RX_STAT_EN
    ,
    .rt_o_viol_cnt(viol_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Behavioural model: a queue stands in for the synchronizer delay.
  logic [N-1:0] hist[$];
  int           m_mode, m_bad, m_viol;
  logic [N-1:0] m_prev, m_bin, m_delta;
  logic         m_chg, m_dir, m_err;

  function automatic logic [N-1:0] g2b(input logic [N-1:0] g);
    logic [N-1:0] b = g;
    for (int s = 1; s < N; s++) b = b ^ (g >> s);
    return b;
  endfunction

  function automatic logic [N-1:0] b2g(input logic [N-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < STG; i++) hist.push_back('0);
    m_mode = M_IDLE; m_bad = 0; m_viol = 0;
    m_prev = '0; m_bin = '0; m_delta = '0;
    m_chg = 1'b0; m_dir = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step();
    logic [N-1:0] gs, nb;
    int d;
    gs = hist.pop_front();
    hist.push_back(gray);
    m_chg = 1'b0;
    if (!en) m_mode = M_IDLE;
    else begin
      case (m_mode)
        M_IDLE: m_mode = M_ACQ;
        M_ACQ: begin
          m_prev = gs; m_bin = g2b(gs); m_delta = '0; m_bad = 0; m_mode = M_TRACK;
        end
        M_TRACK: begin
          d = $countones(gs ^ m_prev);
          if (d == 0) m_bad = 0;
          else if (d == 1) begin
            nb = g2b(gs);
            m_delta = nb - m_bin;
            m_bin = nb;
            m_chg = 1'b1;
            m_dir = (m_delta == 32'hFFFF_FFFF);
            m_prev = gs;
            m_bad = 0;
          end else begin
            m_bad++;
            if (m_viol < 65535) m_viol++;
            if (m_bad == EMAX) begin m_mode = M_ERR; m_err = 1'b1; end
          end
        end
        default: if (clr) m_mode = M_ACQ;
      endcase
    end
    if (clr) begin m_err = 1'b0; m_viol = 0; end
  endtask

  task automatic check_outputs(input string ph);
    check({ph, ":bin"},   bin,       m_bin);
    check({ph, ":vld"},   N'(vld),   N'(m_mode == M_TRACK));
    check({ph, ":delta"}, delta,     m_delta);
    check({ph, ":chg"},   N'(chg),   N'(m_chg));
    check({ph, ":dir"},   N'(dir),   N'(m_dir));
    check({ph, ":err"},   N'(err),   N'(m_err));
`ifdef RT_GRAY_RX_STAT_EN
    check({ph, ":viol"},  N'(viol_cnt), N'(m_viol));
`endif
  endtask

  task automatic step(input string ph);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs(ph);
  endtask

  task automatic steps(input string ph, input int n);
    for (int i = 0; i < n; i++) step(ph);
  endtask

  task automatic check_all_zero(input string ph);
    check({ph, ":bin"},   bin,      '0);
    check({ph, ":vld"},   N'(vld),  '0);
    check({ph, ":delta"}, delta,    '0);
    check({ph, ":chg"},   N'(chg),  '0);
    check({ph, ":dir"},   N'(dir),  '0);
    check({ph, ":err"},   N'(err),  '0);
  endtask

  initial begin
    int pulses, hold, r;
    logic [N-1:0] b;

    // Reset held with a non-zero input: nothing moves.
    gray = 32'h0000_0005;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_all_zero("reset");
    end
    rst_n = 1'b1;

    // Acquire a steady value.
    gray = 32'h0000_0003;
    steps("pre_acq", 4);
    en = 1'b1;
    steps("acq", STG + 2);
    check("acq:vld_c", N'(vld), N'(1));
    check("acq:bin_c", bin, 32'h0000_0002);

    // Single increment: one chg pulse.
    gray = 32'h0000_0002;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step("inc");
      pulses += int'(chg);
    end
    check("inc:pulses", N'(pulses), N'(1));
    check("inc:bin_c", bin, 32'h0000_0003);
    check("inc:delta_c", delta, 32'h0000_0001);
    check("inc:dir_c", N'(dir), N'(0));

    // Held multi-bit jump -> ERR; clr_err re-acquires.
    gray = 32'h0000_0005;
    steps("viol", 6);
    check("viol:err_c", N'(err), N'(1));
    check("viol:vld_c", N'(vld), N'(0));
    check("viol:bin_c", bin, 32'h0000_0003);
    clr = 1'b1;
    step("clr");
    clr = 1'b0;
    steps("reacq", 3);
    check("reacq:bin_c", bin, 32'h0000_0006);
    check("reacq:vld_c", N'(vld), N'(1));
    check("reacq:err_c", N'(err), N'(0));

    // Error sticky across disable; clr_err in TRACK clears it without a state change.
    gray = 32'h0000_0002;
    steps("viol2", 6);
    en = 1'b0;
    step("dis");
    check("dis:vld_c", N'(vld), N'(0));
    check("dis:err_c", N'(err), N'(1));
    en = 1'b1;
    steps("reen", 3);
    check("reen:err_c", N'(err), N'(1));
    check("reen:vld_c", N'(vld), N'(1));
    clr = 1'b1;
    step("clr2");
    clr = 1'b0;
    step("clr2");
    check("clr2:err_c", N'(err), N'(0));
    check("clr2:vld_c", N'(vld), N'(1));

    // Wrap in both directions.
    gray = 32'h0000_0000;
    steps("to0", 4);
    gray = 32'h8000_0000;
    steps("wrapdn", 4);
    check("wrapdn:bin_c", bin, 32'hFFFF_FFFF);
    check("wrapdn:delta_c", delta, 32'hFFFF_FFFF);
    check("wrapdn:dir_c", N'(dir), N'(1));
    gray = 32'h0000_0000;
    steps("wrapup", 4);
    check("wrapup:bin_c", bin, 32'h0000_0000);
    check("wrapup:delta_c", delta, 32'h0000_0001);
    check("wrapup:dir_c", N'(dir), N'(0));

    // Asynchronous reset in the middle of a cycle.
    gray = 32'h0000_0001;
    steps("pre_rst", 4);
    #2 rst_n = 1'b0;
    #1 check_all_zero("arst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    steps("post_rst", STG + 3);
    check("post_rst:vld_c", N'(vld), N'(1));
    check("post_rst:bin_c", bin, 32'h0000_0001);

    // Randomized walk: legal steps, holds, held jumps, enable drops, clears.
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      en  = ($urandom_range(0, 99) >= 2);
      clr = ($urandom_range(0, 99) < 3);
      if (hold > 0) hold--;
      else begin
        r = $urandom_range(0, 99);
        if (r < 60) begin
          b = g2b(gray);
          b = ($urandom_range(0, 1) == 1) ? b + 32'd1 : b - 32'd1;
          gray = b2g(b);
        end else if (r < 90) begin
          hold = $urandom_range(0, 3);
        end else begin
          case ($urandom_range(0, 2))
            0:       gray = 32'h0000_0000;
            1:       gray = 32'h8000_0000;
            default: gray = $urandom;
          endcase
          hold = $urandom_range(1, 5);
        end
      end
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
